digdug_cpu_bus_arb: RTL and testbench
=====================================

// Module: digdug_cpu_bus_arb
// PURPOSE
//  Shares the single I/O-device bus (AD/WR/RD/DI in, DO/DV out) among the three game CPUs.
//  Sits directly upstream of the I/O device: captures per-CPU accesses to $6800-$A007 space,
//  round-robin serialises them onto one bus cycle each, returns read data, and holds each CPU in WAIT meanwhile.
//  CPU reset lines from the CPU control latches flush the matching CPU's pending access.
// PARAMETERS
//  AW    16  address width per CPU and on the shared bus
//  DW    8   data width
//  NCPU  3   number of CPU ports (fixed at 3; the banner and bench cover only 3)
// PORTS
//  CL         in   1         bus clock; all state on posedge CL
//  RESET_N    in   1         reset, asynchronous, active-low
//  CREQ       in   NCPU      per-CPU access request, level, held until CACK
//  CWR        in   NCPU      per-CPU write strobe (1=write, 0=read), valid with CREQ
//  CAD        in   NCPU*AW   per-CPU address, CPU i at [i*AW +: AW]
//  CDI        in   NCPU*DW   per-CPU write data
//  CRST       in   NCPU      per-CPU reset from CPU control latch (1=CPU held in reset)
//  CWAIT      out  NCPU      stall to CPU i while its access is pending
//  CACK       out  NCPU      1-cycle pulse: access of CPU i complete
//  CDO        out  NCPU*DW   read data returned to CPU i, held until its next ACK
//  CDV        out  NCPU      I/O device claimed the read (DV), held with CDO
//  AD         out  AW        shared bus address
//  WR         out  1         shared bus write strobe, 1 cycle
//  RD         out  1         shared bus read strobe, 1 cycle
//  DI         out  DW        shared bus write data
//  DO         in   DW        shared bus read data (combinational from device)
//  DV         in   1         shared bus data-valid
// BEHAVIOUR
//  Reset: CWAIT=0, CACK=0, CDO=all 8'hFF, CDV=0, AD=0, WR=0, RD=0, DI=0, FSM=IDLE, RR pointer=0, all ARM=1.
//  Per-CPU ARM flag: cleared on that CPU's CACK, set when CREQ[i] seen low; a request is PENDING
//   when CREQ[i]&ARM[i]&~CRST[i]. CWAIT[i] is combinational: PENDING[i] or (FSM busy with grantee i).
//   -> WAIT asserts in the same cycle as CREQ; no access is ever serviced twice for one held CREQ.
//  FSM (one access = 3 cycles):
//   IDLE:    if any PENDING, pick first pending CPU at/after RR pointer (i, i+1, i+2 mod 3);
//            latch CAD/CDI/CWR of grantee into bus registers; -> ISSUE. Else stay.
//   ISSUE:   AD/DI driven from registers; WR=latched CWR, RD=~latched CWR, for exactly this cycle; -> CAPTURE.
//   CAPTURE: AD held, WR=RD=0; on read, CDO[g]<=DO, CDV[g]<=DV (writes leave CDO/CDV unchanged);
//            CACK[g]=1 for this cycle; ARM[g]<=0; RR pointer <= g+1 mod 3; -> IDLE.
//  Latency: CREQ rising in cycle n (FSM idle) -> strobe in n+1 -> CACK and data in n+2; WAIT low n+3.
//  Worst case with all three pending: 9 cycles for the last grantee.
//  RR pointer wraps 2->0. Fairness: a CPU re-requesting immediately cannot starve others.
//  CRST[i] rising: PENDING[i] drops at once. If i is grantee in ISSUE, the strobe still completes
//   (device state changes are not undone) but CAPTURE suppresses CACK[i] and CDO/CDV update; ARM[i] set.
//  CREQ dropped by CPU before ACK (protocol violation): same as CRST flush; no error flag.
//  Address/data change while WAIT high: ignored after the IDLE latch cycle.
//  Async RESET_N mid-access: all outputs to reset values immediately; in-flight strobe aborted.
// STRUCTURE
//  Shared package digdug_pkg: NCPU constant, FSM state enum {IDLE,ISSUE,CAPTURE}, RR pointer type
//   (2-bit, values 0..2), CDO reset value 8'hFF.
//  One sub-module: digdug_rr_pick3 (combinational: pending[2:0], ptr -> grant index, grant valid).
//  Top holds FSM, ARM flags, bus registers, per-CPU return registers.
// TESTING
//  1 Reset: RESET_N low mid-ISSUE -> WR/RD/CWAIT/CACK=0, CDO=8'hFF x3 within same cycle.
//  2 CPU0 read $7000, DO=8'h5A DV=1 -> RD pulse cycle n+1 AD=16'h7000, CACK[0] at n+2, CDO0=8'h5A, CDV0=1.
//  3 CPU0,1,2 request same cycle, ptr=0 -> strobes in order 0,1,2 at n+1,n+4,n+7; ptr ends 0.
//  4 CPU1 write $A002 DI=8'h01, holds CREQ 10 cycles -> exactly one WR pulse; ARM re-set after CREQ low.
//  5 CRST[2] asserted during CPU2 ISSUE -> strobe seen, no CACK[2], CDO2 unchanged, CWAIT[2]=0.
//  6 CPU0 re-requests each cycle after ACK with CPU1 pending -> CPU1 granted before CPU0 second access.

Source files
------------

// File: rtl/digdug_pkg.sv
// Shared types and constants for the Dig Dug CPU-to-I/O bus arbiter.
package digdug_pkg;

    localparam int NCPU = 3;
    localparam int AW   = 16;
    localparam int DW   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    typedef logic [1:0] rr_ptr_t;

    localparam logic [DW-1:0] CDO_RST = 8'hFF;

    function automatic rr_ptr_t rr_next(input rr_ptr_t p);
        case (p)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/digdug_cpu_bus_arb_if.sv
// Signal bundle between the three CPU ports, the arbiter and the shared I/O-device bus.
interface digdug_cpu_bus_arb_if;
    import digdug_pkg::*;

    logic [NCPU-1:0]    CREQ;
    logic [NCPU-1:0]    CWR;
    logic [NCPU*AW-1:0] CAD;
    logic [NCPU*DW-1:0] CDI;
    logic [NCPU-1:0]    CRST;
    logic [NCPU-1:0]    CWAIT;
    logic [NCPU-1:0]    CACK;
    logic [NCPU*DW-1:0] CDO;
    logic [NCPU-1:0]    CDV;
    logic [AW-1:0]      AD;
    logic               WR;
    logic               RD;
    logic [DW-1:0]      DI;
    logic [DW-1:0]      DO;
    logic               DV;

    modport master (
        input  CREQ, CWR, CAD, CDI, CRST, DO, DV,
        output CWAIT, CACK, CDO, CDV, AD, WR, RD, DI
    );

    modport slave (
        output CREQ, CWR, CAD, CDI, CRST, DO, DV,
        input  CWAIT, CACK, CDO, CDV, AD, WR, RD, DI
    );

endinterface

// File: rtl/digdug_rr_pick3.sv
// Round-robin selector: first pending CPU at or after the pointer, wrapping 2->0.
module digdug_rr_pick3
    import digdug_pkg::*;
(
    input  logic [NCPU-1:0] pending_i,
    input  rr_ptr_t         ptr_i,
    output rr_ptr_t         grant_o,
    output logic            valid_o
);

    logic [2:0] sel_s;

    // Returns {valid, index} for the first set bit in the search order a, b, c.
    function automatic logic [2:0] first_of(input logic [2:0] pend,
                                            input rr_ptr_t a, input rr_ptr_t b, input rr_ptr_t c);
        if (pend[a]) begin
            first_of = {1'b1, a};
        end else if (pend[b]) begin
            first_of = {1'b1, b};
        end else if (pend[c]) begin
            first_of = {1'b1, c};
        end else begin
            first_of = {1'b0, 2'd0};
        end
    endfunction

    // Rotate the search order by the pointer.
    always_comb begin
        sel_s = 3'b000;
        case (ptr_i)
            2'd0:    sel_s = first_of(pending_i, 2'd0, 2'd1, 2'd2);
            2'd1:    sel_s = first_of(pending_i, 2'd1, 2'd2, 2'd0);
            2'd2:    sel_s = first_of(pending_i, 2'd2, 2'd0, 2'd1);
            default: sel_s = first_of(pending_i, 2'd0, 2'd1, 2'd2);
        endcase
    end

    assign grant_o = sel_s[1:0];
    assign valid_o = sel_s[2];

endmodule

// File: rtl/digdug_cpu_bus_arb.sv
// Serialises the three CPUs' I/O accesses onto the shared device bus, one 3-cycle
// access at a time, returning read data and stalling each CPU until its access completes.
module digdug_cpu_bus_arb
    import digdug_pkg::*;
(
    input  logic                 CL,
    input  logic                 RESET_N,
    digdug_cpu_bus_arb_if.master bus
);

    state_e                 state_q, state_d;
    rr_ptr_t                ptr_q, ptr_d;
    rr_ptr_t                gnt_q, gnt_d;
    rr_ptr_t                pick_s;
    logic                   pick_vld_s;
    logic [NCPU-1:0]        arm_q, arm_d;
    logic [NCPU-1:0]        cack_q, cack_d;
    logic [NCPU-1:0]        cdv_q, cdv_d;
    logic [NCPU-1:0][DW-1:0] cdo_q, cdo_d;
    logic [AW-1:0]          ad_q, ad_d;
    logic [DW-1:0]          di_q, di_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   iswr_q, iswr_d;
    logic [NCPU-1:0]        pending_s;
    logic [NCPU-1:0]        cwait_s;
    logic                   flush_s;
    logic [NCPU-1:0][AW-1:0] cad_s;
    logic [NCPU-1:0][DW-1:0] cdi_s;

    assign cad_s = bus.CAD;
    assign cdi_s = bus.CDI;

    // ARM keeps a held CREQ from being serviced twice.
    assign pending_s = bus.CREQ & arm_q & ~bus.CRST;

    // A grantee that dropped its request or went into reset mid-access is flushed.
    assign flush_s = bus.CRST[gnt_q] | ~bus.CREQ[gnt_q];

    digdug_rr_pick3 u_pick (
        .pending_i (pending_s),
        .ptr_i     (ptr_q),
        .grant_o   (pick_s),
        .valid_o   (pick_vld_s)
    );

    // WAIT follows the request combinationally and stays up while the grantee's access is in flight.
    always_comb begin
        cwait_s = {NCPU{1'b0}};
        for (int i = 0; i < NCPU; i++) begin
            if (RESET_N && (pending_s[i] || ((state_q != IDLE) && (gnt_q == rr_ptr_t'(i))))) begin
                cwait_s[i] = 1'b1;
            end else begin
                cwait_s[i] = 1'b0;
            end
        end
    end

    // Access sequencer: IDLE grants and latches, ISSUE strobes, CAPTURE acknowledges.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ad_d    = ad_q;
        di_d    = di_q;
        iswr_d  = iswr_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        cack_d  = {NCPU{1'b0}};
        cdo_d   = cdo_q;
        cdv_d   = cdv_q;
        arm_d   = arm_q | ~bus.CREQ | bus.CRST;

        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    gnt_d   = pick_s;
                    ad_d    = cad_s[pick_s];
                    di_d    = cdi_s[pick_s];
                    iswr_d  = bus.CWR[pick_s];
                    wr_d    = bus.CWR[pick_s];
                    rd_d    = ~bus.CWR[pick_s];
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
                // Ack and read data are registered here so they appear together in CAPTURE.
                if (flush_s) begin
                    arm_d[gnt_q] = 1'b1;
                end else begin
                    cack_d[gnt_q] = 1'b1;
                    arm_d[gnt_q]  = 1'b0;
                    if (!iswr_q) begin
                        cdo_d[gnt_q] = bus.DO;
                        cdv_d[gnt_q] = bus.DV;
                    end else begin
                        cdo_d = cdo_q;
                    end
                end
            end
            CAPTURE: begin
                ptr_d   = rr_next(gnt_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset aborts any in-flight strobe.
    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 2'd0;
            arm_q   <= {NCPU{1'b1}};
            cack_q  <= {NCPU{1'b0}};
            cdv_q   <= {NCPU{1'b0}};
            cdo_q   <= {NCPU{CDO_RST}};
            ad_q    <= 16'h0000;
            di_q    <= 8'h00;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            iswr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            arm_q   <= arm_d;
            cack_q  <= cack_d;
            cdv_q   <= cdv_d;
            cdo_q   <= cdo_d;
            ad_q    <= ad_d;
            di_q    <= di_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            iswr_q  <= iswr_d;
        end
    end

    assign bus.CWAIT = cwait_s;
    assign bus.CACK  = cack_q;
    assign bus.CDO   = cdo_q;
    assign bus.CDV   = cdv_q;
    assign bus.AD    = ad_q;
    assign bus.WR    = wr_q;
    assign bus.RD    = rd_q;
    assign bus.DI    = di_q;

endmodule

// File: tb/tb_digdug_cpu_bus_arb.sv
// Bench for digdug_cpu_bus_arb: directed scenarios plus randomized CPU traffic against a transaction-level model.
module tb_digdug_cpu_bus_arb;
    import digdug_pkg::*;

    logic CL = 1'b0;
    logic RESET_N = 1'b0;
    logic mem_clr = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] dev_mem [256];

    always #5 CL = ~CL;

    digdug_cpu_bus_arb_if bus();

    digdug_cpu_bus_arb dut (
        .CL      (CL),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    function automatic logic [7:0] dev_init(input logic [7:0] a);
        return 8'h5A ^ (a * 8'd37);
    endfunction

    // I/O device: combinational read, claims addresses with bit 8 clear.
    assign bus.DO = dev_mem[bus.AD[7:0]];
    assign bus.DV = ~bus.AD[8];

    always @(posedge CL) begin
        if (mem_clr) begin
            for (int a = 0; a < 256; a++) dev_mem[a] <= dev_init(8'(a));
        end else if (bus.WR) begin
            dev_mem[bus.AD[7:0]] <= bus.DI;
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.CWR[i]         = wr;
        bus.CAD[i*16 +: 16] = a;
        bus.CDI[i*8 +: 8]   = d;
        bus.CREQ[i]        = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N  = 1'b0;
        mem_clr  = 1'b1;
        bus.CREQ = 3'b000; bus.CWR = 3'b000; bus.CRST = 3'b000;
        bus.CAD  = 48'h0; bus.CDI = 24'h0;
        repeat (2) @(negedge CL);
        mem_clr = 1'b0;
        total++; if (bus.CDO !== 24'hFFFFFF) begin bad++; $display("FAIL reset_cdo: got %h exp ffffff", bus.CDO); end
        total++; if ({bus.CWAIT, bus.CACK, bus.CDV} !== 9'h000) begin bad++; $display("FAIL reset_flags: got %h exp 000", {bus.CWAIT, bus.CACK, bus.CDV}); end
        total++; if ({bus.AD, bus.DI, bus.WR, bus.RD} !== 26'h0) begin bad++; $display("FAIL reset_bus: got %h exp 0", {bus.AD, bus.DI, bus.WR, bus.RD}); end
        RESET_N = 1'b1;
    endtask

    task automatic test_all_three();
        logic [15:0] exp_ad;
        logic [2:0]  exp_ack;
        set_req(0, 1'b0, 16'h7001, 8'h00);
        set_req(1, 1'b0, 16'h8102, 8'h00);
        set_req(2, 1'b0, 16'h9003, 8'h00);
        #1;
        total++; if (bus.CWAIT !== 3'b111) begin bad++; $display("FAIL all3_wait_same_cycle: got %b exp 111", bus.CWAIT); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge CL);
            exp_ad  = (c == 1) ? 16'h7001 : (c == 4) ? 16'h8102 : 16'h9003;
            exp_ack = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            total++; if ((bus.RD | bus.WR) !== (c == 1 || c == 4 || c == 7)) begin bad++; $display("FAIL all3_strobe c=%0d: got %b", c, bus.RD | bus.WR); end
            if (c == 1 || c == 4 || c == 7) begin
                total++; if (bus.AD !== exp_ad) begin bad++; $display("FAIL all3_ad c=%0d: got %h exp %h", c, bus.AD, exp_ad); end
            end
            total++; if (bus.CACK !== exp_ack) begin bad++; $display("FAIL all3_ack c=%0d: got %b exp %b", c, bus.CACK, exp_ack); end
            if (c == 8) begin
                total++; if (bus.CWAIT[2] !== 1'b1) begin bad++; $display("FAIL all3_wait2_busy: got %b exp 1", bus.CWAIT[2]); end
            end
            if (c == 9) begin
                total++; if (bus.CWAIT !== 3'b000) begin bad++; $display("FAIL all3_wait_done: got %b exp 000", bus.CWAIT); end
            end
            for (int i = 0; i < 3; i++) if (bus.CACK[i]) bus.CREQ[i] = 1'b0;
        end
        total++; if (bus.CDO !== {dev_init(8'h03), dev_init(8'h02), dev_init(8'h01)}) begin bad++; $display("FAIL all3_cdo: got %h", bus.CDO); end
        total++; if (bus.CDV !== 3'b101) begin bad++; $display("FAIL all3_cdv: got %b exp 101", bus.CDV); end
        // pointer is back at 0: CPU0 must beat CPU2
        set_req(0, 1'b0, 16'h7004, 8'h00);
        set_req(2, 1'b0, 16'h9005, 8'h00);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CL);
            if (c == 1) begin
                total++; if (bus.AD !== 16'h7004 || bus.RD !== 1'b1) begin bad++; $display("FAIL ptr_wrap_first: got %h exp 7004", bus.AD); end
            end
            if (c == 4) begin
                total++; if (bus.AD !== 16'h9005 || bus.RD !== 1'b1) begin bad++; $display("FAIL ptr_wrap_second: got %h exp 9005", bus.AD); end
            end
            for (int i = 0; i < 3; i++) if (bus.CACK[i]) bus.CREQ[i] = 1'b0;
        end
    endtask

    task automatic test_single_read();
        @(negedge CL);
        set_req(0, 1'b0, 16'h7000, 8'h00);
        #1;
        total++; if (bus.CWAIT[0] !== 1'b1) begin bad++; $display("FAIL read_wait_n: got %b exp 1", bus.CWAIT[0]); end
        @(negedge CL);
        total++; if ({bus.RD, bus.WR, bus.AD} !== {1'b1, 1'b0, 16'h7000}) begin bad++; $display("FAIL read_strobe_n1: got %b%b %h exp 10 7000", bus.RD, bus.WR, bus.AD); end
        @(negedge CL);
        total++; if (bus.CACK !== 3'b001) begin bad++; $display("FAIL read_ack_n2: got %b exp 001", bus.CACK); end
        total++; if ({bus.CDO[7:0], bus.CDV[0]} !== {8'h5A, 1'b1}) begin bad++; $display("FAIL read_data_n2: got %h/%b exp 5a/1", bus.CDO[7:0], bus.CDV[0]); end
        @(negedge CL);
        total++; if ({bus.CWAIT[0], bus.CACK} !== 4'b0000) begin bad++; $display("FAIL read_release_n3: got %b%b exp 0000", bus.CWAIT[0], bus.CACK); end
        bus.CREQ[0] = 1'b0;
    endtask

    task automatic test_write_hold();
        int wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, seen = 0;
        logic [7:0] di_seen = 8'h00;
        @(negedge CL);
        set_req(1, 1'b1, 16'hA002, 8'h01);
        for (int c = 1; c <= 10; c++) begin
            @(negedge CL);
            if (bus.WR) begin wr_cnt++; di_seen = bus.DI; end
            if (bus.RD) rd_cnt++;
            if (bus.CACK[1]) ack_cnt++;
        end
        total++; if (wr_cnt != 1 || rd_cnt != 0) begin bad++; $display("FAIL hold_single_wr: got wr=%0d rd=%0d exp 1/0", wr_cnt, rd_cnt); end
        total++; if (ack_cnt != 1) begin bad++; $display("FAIL hold_single_ack: got %0d exp 1", ack_cnt); end
        total++; if (di_seen !== 8'h01) begin bad++; $display("FAIL hold_di: got %h exp 01", di_seen); end
        total++; if (bus.CWAIT[1] !== 1'b0) begin bad++; $display("FAIL hold_wait_low: got %b exp 0", bus.CWAIT[1]); end
        bus.CREQ[1] = 1'b0;
        @(negedge CL);
        set_req(1, 1'b1, 16'hA002, 8'h02);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CL);
            if (bus.WR && bus.DI === 8'h02) seen++;
            if (bus.CACK[1]) bus.CREQ[1] = 1'b0;
        end
        total++; if (seen != 1) begin bad++; $display("FAIL rearm_second_wr: got %0d exp 1", seen); end
    endtask

    task automatic test_crst_flush();
        @(negedge CL);
        set_req(2, 1'b0, 16'h7003, 8'h00);
        @(negedge CL);
        total++; if ({bus.RD, bus.AD} !== {1'b1, 16'h7003}) begin bad++; $display("FAIL crst_strobe: got %b %h exp 1 7003", bus.RD, bus.AD); end
        bus.CRST[2] = 1'b1;
        @(negedge CL);
        total++; if (bus.CACK !== 3'b000) begin bad++; $display("FAIL crst_no_ack: got %b exp 000", bus.CACK); end
        @(negedge CL);
        total++; if (bus.CWAIT[2] !== 1'b0) begin bad++; $display("FAIL crst_wait: got %b exp 0", bus.CWAIT[2]); end
        total++; if ({bus.CDO[23:16], bus.CDV[2]} !== {dev_init(8'h05), 1'b1}) begin bad++; $display("FAIL crst_cdo_kept: got %h/%b", bus.CDO[23:16], bus.CDV[2]); end
        bus.CREQ[2] = 1'b0;
        bus.CRST[2] = 1'b0;
    endtask

    task automatic test_fairness();
        logic [15:0] order [$];
        @(negedge CL);
        set_req(0, 1'b0, 16'h7010, 8'h00);
        @(negedge CL);
        total++; if ({bus.RD, bus.AD} !== {1'b1, 16'h7010}) begin bad++; $display("FAIL fair_first: got %b %h exp 1 7010", bus.RD, bus.AD); end
        set_req(1, 1'b0, 16'h7011, 8'h00);
        @(negedge CL);
        total++; if (bus.CACK !== 3'b001) begin bad++; $display("FAIL fair_ack0: got %b exp 001", bus.CACK); end
        bus.CREQ[0] = 1'b0;
        @(negedge CL);
        set_req(0, 1'b0, 16'h7012, 8'h00);
        for (int c = 0; c < 12; c++) begin
            @(negedge CL);
            if (bus.RD | bus.WR) order.push_back(bus.AD);
            for (int i = 0; i < 3; i++) if (bus.CACK[i]) bus.CREQ[i] = 1'b0;
        end
        total++; if (order.size() != 2) begin bad++; $display("FAIL fair_count: got %0d exp 2", order.size()); end
        else begin
            total++; if (order[0] !== 16'h7011 || order[1] !== 16'h7012) begin bad++; $display("FAIL fair_order: got %h,%h exp 7011,7012", order[0], order[1]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CL);
        set_req(0, 1'b0, 16'h7020, 8'h00);
        @(negedge CL);
        total++; if (bus.RD !== 1'b1) begin bad++; $display("FAIL midrst_issue: got %b exp 1", bus.RD); end
        RESET_N = 1'b0;
        #1;
        total++; if ({bus.WR, bus.RD, bus.CWAIT, bus.CACK} !== 8'h00) begin bad++; $display("FAIL midrst_flags: got %b%b %b %b exp 0", bus.WR, bus.RD, bus.CWAIT, bus.CACK); end
        total++; if (bus.CDO !== 24'hFFFFFF) begin bad++; $display("FAIL midrst_cdo: got %h exp ffffff", bus.CDO); end
        bus.CREQ = 3'b000;
        @(negedge CL);
        RESET_N = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  req, served, snap, exp_ack;
        logic [15:0] m_addr [3];
        logic        m_wr [3];
        logic [7:0]  m_data [3];
        logic [7:0]  model_mem [256];
        logic [7:0]  exp_cdo [3];
        logic [2:0]  exp_cdv;
        int mptr, last_strobe, last_g, g;
        logic exp_strobe;
        RESET_N = 1'b0; mem_clr = 1'b1;
        bus.CREQ = 3'b000; bus.CRST = 3'b000;
        repeat (2) @(negedge CL);
        mem_clr = 1'b0; RESET_N = 1'b1;
        for (int a = 0; a < 256; a++) model_mem[a] = dev_init(8'(a));
        for (int i = 0; i < 3; i++) exp_cdo[i] = 8'hFF;
        exp_cdv = 3'b000; req = 3'b000; served = 3'b000; snap = 3'b000;
        mptr = 0; last_strobe = -100; last_g = 0;
        for (int j = 0; j < 800; j++) begin
            @(negedge CL);
            total++; if (bus.CDO !== {exp_cdo[2], exp_cdo[1], exp_cdo[0]} || bus.CDV !== exp_cdv) begin
                bad++; $display("FAIL rnd_cdo j=%0d: got %h/%b exp %h/%b", j, bus.CDO, bus.CDV, {exp_cdo[2], exp_cdo[1], exp_cdo[0]}, exp_cdv);
            end
            exp_ack = (last_strobe == j - 1) ? (3'b001 << last_g) : 3'b000;
            total++; if (bus.CACK !== exp_ack) begin bad++; $display("FAIL rnd_ack j=%0d: got %b exp %b", j, bus.CACK, exp_ack); end
            total++; if (bus.CWAIT !== req) begin bad++; $display("FAIL rnd_wait j=%0d: got %b exp %b", j, bus.CWAIT, req); end
            exp_strobe = (snap != 3'b000) && (j - 1 >= last_strobe + 2);
            total++; if ((bus.WR | bus.RD) !== exp_strobe) begin bad++; $display("FAIL rnd_strobe j=%0d: got %b exp %b", j, bus.WR | bus.RD, exp_strobe); end
            if (exp_strobe) begin
                g = -1;
                for (int k = 0; k < 3; k++) if (g < 0 && snap[(mptr + k) % 3]) g = (mptr + k) % 3;
                total++; if (bus.AD !== m_addr[g] || bus.WR !== m_wr[g] || bus.RD !== !m_wr[g] || (m_wr[g] && bus.DI !== m_data[g])) begin
                    bad++; $display("FAIL rnd_grant j=%0d: got ad=%h wr=%b di=%h exp cpu%0d ad=%h wr=%b di=%h", j, bus.AD, bus.WR, bus.DI, g, m_addr[g], m_wr[g], m_data[g]);
                end
                served[g] = 1'b1; last_strobe = j; last_g = g; mptr = (g + 1) % 3;
                if (m_wr[g]) model_mem[m_addr[g][7:0]] = m_data[g];
                else begin exp_cdo[g] = model_mem[m_addr[g][7:0]]; exp_cdv[g] = ~m_addr[g][8]; end
            end
            for (int i = 0; i < 3; i++) begin
                if (exp_ack[i]) begin
                    req[i] = 1'b0; served[i] = 1'b0; bus.CREQ[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    m_addr[i] = 16'h6800 + 16'($urandom_range(0, 16'h3807));
                    m_wr[i]   = 1'($urandom_range(0, 1));
                    m_data[i] = 8'($urandom_range(0, 255));
                    set_req(i, m_wr[i], m_addr[i], m_data[i]);
                end
            end
            snap = req & ~served;
        end
    endtask

    initial begin
        test_reset();
        test_all_three();
        test_single_read();
        test_write_hold();
        test_crst_flush();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
